// File: rtl/spike_event_monitor.sv
// Turns the neuron's level spike into timestamped single-cycle events buffered in a
// first-word-fall-through FIFO, and measures spike rate over a fixed window.
module spike_event_monitor #(
  parameter int TS_W       = 8,
  parameter int DEPTH      = 4,
  parameter int WIN_CYCLES = 256,
  parameter int CNT_W      = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       en,
  input  logic                       spike_in,
  input  logic                       clr_ovf,
  input  logic                       evt_ready,
  output logic                       evt_valid,
  output logic [TS_W-1:0]            evt_ts,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow,
  output logic [CNT_W-1:0]           rate_out,
  output logic                       rate_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int WW = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;

  logic                   spike_q, spike_d;
  logic [TS_W-1:0]        ts_q, ts_d;
  logic [TS_W-1:0]        mem_q [DEPTH];
  logic [TS_W-1:0]        mem_d [DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic                   overflow_q, overflow_d;
  logic [WW-1:0]          win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]       spk_cnt_q, spk_cnt_d;
  logic [CNT_W-1:0]       rate_q, rate_d;
  logic                   rate_valid_q, rate_valid_d;

  logic                   evt;
  logic                   empty;
  logic                   full;
  logic                   pop;
  logic                   push;
  logic                   drop;
  logic                   win_last;
  logic [CNT_W-1:0]       spk_sum;

  always_comb begin
    evt      = en & spike_in & ~spike_q;
    empty    = (level_q == '0);
    full     = (level_q == LW'(DEPTH));
    pop      = evt_ready & ~empty;
    // A full FIFO can still accept a push when the head leaves in the same cycle
    push     = evt & (~full | pop);
    drop     = evt & full & ~pop;
    win_last = (win_cnt_q == WW'(WIN_CYCLES - 1));
    spk_sum  = (evt && (spk_cnt_q != '1)) ? spk_cnt_q + CNT_W'(1) : spk_cnt_q;
  end

  always_comb begin
    spike_d      = spike_in;
    ts_d         = ts_q;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    overflow_d   = overflow_q;
    win_cnt_d    = win_cnt_q;
    spk_cnt_d    = spk_cnt_q;
    rate_d       = rate_q;
    rate_valid_d = 1'b0;

    if (push) begin
      mem_d[wr_ptr_q] = ts_q;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end

    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end

    if (en) begin
      ts_d = ts_q + TS_W'(1);
      if (win_last) begin
        win_cnt_d    = '0;
        rate_d       = spk_sum;
        rate_valid_d = 1'b1;
        spk_cnt_d    = '0;
      end else begin
        win_cnt_d = win_cnt_q + WW'(1);
        spk_cnt_d = spk_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      spike_q      <= 1'b0;
      ts_q         <= '0;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      win_cnt_q    <= '0;
      spk_cnt_q    <= '0;
      rate_q       <= '0;
      rate_valid_q <= 1'b0;
    end else begin
      spike_q      <= spike_d;
      ts_q         <= ts_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      win_cnt_q    <= win_cnt_d;
      spk_cnt_q    <= spk_cnt_d;
      rate_q       <= rate_d;
      rate_valid_q <= rate_valid_d;
    end
  end

  assign evt_valid  = ~empty;
  assign evt_ts     = empty ? '0 : mem_q[rd_ptr_q];
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign rate_out   = rate_q;
  assign rate_valid = rate_valid_q;

endmodule

// File: tb/tb_spike_event_monitor.sv
// Directed bench for spike_event_monitor: a main instance checked against a queue-based
// scoreboard every cycle, plus a small-width instance for rate saturation and ts wrap.
module tb_spike_event_monitor;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic       spike_in;
  logic       clr_ovf;
  logic       evt_ready;

  logic       evt_valid;
  logic [7:0] evt_ts;
  logic [2:0] fifo_level;
  logic       overflow;
  logic [7:0] rate_out;
  logic       rate_valid;

  logic       s_evt_valid;
  logic [3:0] s_evt_ts;
  logic [2:0] s_fifo_level;
  logic       s_overflow;
  logic [2:0] s_rate_out;
  logic       s_rate_valid;

  int testCount = 0;
  int failCount = 0;

  int scoreQ[$];
  int mTs, mWin, mCnt, mRate;
  bit mRv, mOvf, mPrev;

  always #5 clk = ~clk;

  spike_event_monitor #(.TS_W(8), .DEPTH(4), .WIN_CYCLES(16), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .spike_in(spike_in), .clr_ovf(clr_ovf),
    .evt_ready(evt_ready), .evt_valid(evt_valid), .evt_ts(evt_ts), .fifo_level(fifo_level),
    .overflow(overflow), .rate_out(rate_out), .rate_valid(rate_valid)
  );

  spike_event_monitor #(.TS_W(4), .DEPTH(4), .WIN_CYCLES(32), .CNT_W(3)) dut_s (
    .clk(clk), .reset_n(reset_n), .en(en), .spike_in(spike_in), .clr_ovf(clr_ovf),
    .evt_ready(evt_ready), .evt_valid(s_evt_valid), .evt_ts(s_evt_ts), .fifo_level(s_fifo_level),
    .overflow(s_overflow), .rate_out(s_rate_out), .rate_valid(s_rate_valid)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic updateModel();
    bit evt, pop, full, drop;
    int sum;
    if (!reset_n) begin
      scoreQ.delete();
      mTs = 0; mWin = 0; mCnt = 0; mRate = 0; mRv = 0; mOvf = 0; mPrev = 0;
      return;
    end
    evt  = en && spike_in && !mPrev;
    pop  = evt_ready && (scoreQ.size() != 0);
    full = (scoreQ.size() == 4);
    drop = 0;
    if (pop) void'(scoreQ.pop_front());
    if (evt) begin
      if (!full || pop) scoreQ.push_back(mTs);
      else drop = 1;
    end
    if (drop) mOvf = 1;
    else if (clr_ovf) mOvf = 0;
    mRv = 0;
    if (en) begin
      sum = (evt && mCnt < 255) ? mCnt + 1 : mCnt;
      if (mWin == 15) begin
        mRate = sum; mRv = 1; mCnt = 0; mWin = 0;
      end else begin
        mCnt = sum; mWin++;
      end
      mTs = (mTs + 1) % 256;
    end
    mPrev = spike_in;
  endtask

  task automatic checkOutput();
    int head;
    head = (scoreQ.size() != 0) ? scoreQ[0] : 0;
    checkVal("evt_valid", evt_valid, scoreQ.size() != 0);
    checkVal("evt_ts", evt_ts, head);
    checkVal("fifo_level", fifo_level, scoreQ.size());
    checkVal("overflow", overflow, mOvf);
    checkVal("rate_out", rate_out, mRate);
    checkVal("rate_valid", rate_valid, mRv);
    checkVal("s_evt_ts", s_evt_ts, head % 16);
    checkVal("s_fifo_level", s_fifo_level, scoreQ.size());
    checkVal("s_overflow", s_overflow, mOvf);
  endtask

  task automatic applyStimulus(input bit r, input bit e, input bit s, input bit rdy, input bit clr);
    reset_n   = r;
    en        = e;
    spike_in  = s;
    evt_ready = rdy;
    clr_ovf   = clr;
    @(posedge clk);
    updateModel();
    #1;
    checkOutput();
  endtask

  // Hold spike low until the timestamp reaches target, then raise it for one cycle
  task automatic edgeAt(input int target, input bit rdy, input bit clr);
    int n = 0;
    while (mTs != target && n < 300) begin
      applyStimulus(1, 1, 0, 0, 0);
      n++;
    end
    if (n >= 300) begin
      testCount++;
      failCount++;
      $error("[TB] FAIL edge_wait: observed ts %0d expected %0d", mTs, target);
    end
    applyStimulus(1, 1, 1, rdy, clr);
  endtask

  initial begin
    int steps;
    int pulses;
    bit seen;

    reset_n = 0; en = 0; spike_in = 1; evt_ready = 0; clr_ovf = 0;

    // Reset with spike held high; no event after release
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkVal("reset_level", fifo_level, 0);
    checkVal("reset_rate", rate_out, 0);
    applyStimulus(1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 0, 0);
    checkVal("held_no_evt", evt_valid, 0);

    // Single held spike at ts=10
    edgeAt(10, 0, 0);
    checkVal("single_valid", evt_valid, 1);
    checkVal("single_ts", evt_ts, 10);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 1, 0, 0);
    checkVal("single_level", fifo_level, 1);
    applyStimulus(1, 1, 0, 1, 0);
    checkVal("single_drained", fifo_level, 0);

    // Overflow: five edges into a four-entry FIFO
    edgeAt(3, 0, 0);
    edgeAt(6, 0, 0);
    edgeAt(9, 0, 0);
    edgeAt(12, 0, 0);
    edgeAt(15, 0, 0);
    checkVal("ovf_level", fifo_level, 4);
    checkVal("ovf_flag", overflow, 1);
    checkVal("ovf_pop0", evt_ts, 3);
    applyStimulus(1, 1, 0, 1, 0);
    checkVal("ovf_pop1", evt_ts, 6);
    applyStimulus(1, 1, 0, 1, 0);
    checkVal("ovf_pop2", evt_ts, 9);
    applyStimulus(1, 1, 0, 1, 0);
    checkVal("ovf_pop3", evt_ts, 12);
    applyStimulus(1, 1, 0, 1, 0);
    checkVal("ovf_empty", evt_valid, 0);
    applyStimulus(1, 1, 0, 0, 1);
    checkVal("ovf_cleared", overflow, 0);

    // Full FIFO: push and pop in the same cycle
    edgeAt(20, 0, 0);
    edgeAt(22, 0, 0);
    edgeAt(24, 0, 0);
    edgeAt(26, 0, 0);
    edgeAt(28, 1, 0);
    checkVal("fullpp_level", fifo_level, 4);
    checkVal("fullpp_ovf", overflow, 0);
    checkVal("fullpp_head", evt_ts, 22);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 1, 0);
    checkVal("fullpp_tail", evt_ts, 28);
    applyStimulus(1, 1, 0, 1, 0);

    // Drop and clear in the same cycle: set wins
    edgeAt(40, 0, 0);
    edgeAt(42, 0, 0);
    edgeAt(44, 0, 0);
    edgeAt(46, 0, 0);
    edgeAt(48, 0, 1);
    checkVal("clr_drop_ovf", overflow, 1);
    applyStimulus(1, 1, 0, 0, 1);
    checkVal("clr_after", overflow, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 1, 0);

    // Rate: align to window start, toggle for one full window
    steps = 0;
    while (mWin != 0 && steps < 20) begin
      applyStimulus(1, 1, 0, 1, 0);
      steps++;
    end
    for (int i = 0; i < 16; i++) applyStimulus(1, 1, (i % 2) == 0, 1, 0);
    checkVal("rate_pulse", rate_valid, 1);
    checkVal("rate_value", rate_out, 8);

    // Rate with en dropped 5 cycles mid-window; ignored edges while disabled
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, (i % 2) == 0, 1, 0);
    applyStimulus(1, 0, 1, 1, 0);
    applyStimulus(1, 0, 0, 1, 0);
    applyStimulus(1, 0, 1, 1, 0);
    applyStimulus(1, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 1, 0);
    steps = 13;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      applyStimulus(1, 1, (i % 2) == 0, 1, 0);
      steps++;
      if (rate_valid) seen = 1;
    end
    checkVal("rate_delay", steps, 21);
    checkVal("rate_en_value", rate_out, 8);

    // Saturation on the 3-bit rate counter
    pulses = 0;
    for (int i = 0; i < 70; i++) begin
      applyStimulus(1, 1, (i % 2) == 0, 1, 0);
      if (s_rate_valid) begin
        pulses++;
        if (pulses > 1) checkVal("sat_rate", s_rate_out, 7);
      end
    end
    checkVal("sat_pulses", pulses >= 2, 1);

    // Timestamp wrap on the 4-bit instance
    applyStimulus(1, 1, 0, 1, 0);
    edgeAt(78, 0, 0);
    edgeAt(80, 0, 0);
    checkVal("wrap_head", s_evt_ts, 14);
    applyStimulus(1, 1, 0, 1, 0);
    checkVal("wrap_zero", s_evt_ts, 0);
    checkVal("wrap_main", evt_ts, 80);

    // Reset mid-operation discards the FIFO
    applyStimulus(0, 1, 0, 0, 0);
    checkVal("midreset_level", fifo_level, 0);
    checkVal("midreset_valid", evt_valid, 0);
    applyStimulus(1, 1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/spike_event_monitor.md
Name: spike_event_monitor

Overview:
Downstream consumer of the Izhikevich neuron's 1-bit spike output. Converts the level spike (high while v is at or above threshold) into single rising-edge events. Each event is timestamped and buffered in a small FIFO, read out through a valid/ready interface. In parallel, spikes are counted over a fixed window to produce a firing-rate value for the top-level output mux.

Parameters:
TS_W, 8, width of free-running timestamp counter and of evt_ts
DEPTH, 4, FIFO entries; power of 2, >=2
WIN_CYCLES, 256, enabled clock cycles per rate window; >=2
CNT_W, 8, width of rate counter and rate_out

Ports:
clk  in  1  clock
reset_n  in  1  synchronous, active-low reset
en  in  1  global enable; low freezes counters and ignores spikes
spike_in  in  1  level spike from neuron
clr_ovf  in  1  one-cycle pulse, clears overflow
evt_ready  in  1  consumer accepts head entry
evt_valid  out  1  FIFO non-empty
evt_ts  out  TS_W  timestamp of head entry (valid when evt_valid)
fifo_level  out  $clog2(DEPTH)+1  current entry count, 0..DEPTH
overflow  out  1  sticky: an event was dropped because FIFO full
rate_out  out  CNT_W  spike count of last completed window
rate_valid  out  1  one-cycle pulse when rate_out updates

Behaviour:
- Reset (reset_n=0 at clk edge): ts=0, spike_q=0, FIFO empty, fifo_level=0, evt_valid=0, evt_ts=0, overflow=0, win_cnt=0, spk_cnt=0, rate_out=0, rate_valid=0. Reset mid-operation discards all FIFO contents and partial window counts.
- spike_q <= spike_in every cycle regardless of en. This avoids a false edge on re-enable while spike is held high.
- Event condition: en & spike_in & ~spike_q. A spike held high N cycles yields exactly one event.
- ts increments by 1 each cycle en=1, wraps 2^TS_W-1 -> 0, holds when en=0. Event records the ts value present in the cycle the edge is detected, before the increment.
- FIFO push: on event edge; entry visible next cycle. Latency from spike_in rise to evt_valid is 1 cycle when the FIFO was empty. No combinational bypass.
- Pop: evt_valid & evt_ready at clk edge. evt_ts is driven from the head entry, i.e. first-word-fall-through; no added read latency.
- evt_ready while empty: ignored.
- Push when full and no pop: event dropped, existing entries unchanged, overflow <= 1.
- Push and pop in same cycle when full: both succeed, level unchanged, no overflow.
- Push and pop when empty: push only (pop invalid).
- overflow clears on clr_ovf. If clr_ovf and a new drop occur in the same cycle, the set wins (overflow=1).
- fifo_level is registered; it is +1 on push only, -1 on pop only, and unchanged on both or neither.
- Rate window: when en=1, win_cnt counts 0..WIN_CYCLES-1 and wraps. spk_cnt increments per event, saturating at 2^CNT_W-1.
- At the enabled cycle with win_cnt==WIN_CYCLES-1:
  - rate_out <= spk_cnt plus that cycle's event, saturated.
  - rate_valid <= 1 for exactly one cycle.
  - spk_cnt <= 0.
- An event on the boundary cycle counts in the closing window.
- en=0: win_cnt, spk_cnt and ts hold, and no events are generated. FIFO pops continue normally. rate_valid is 0.
- Timestamp wrap is not flagged; the consumer resolves wrap using ordering.

Test Plan:
- Reset: drive reset_n=0 for 2 cycles with spike_in=1, then release -> all outputs 0; no event generated for the already-high spike.
- Single held spike: en=1, spike_in rises when ts=10 and stays high 5 cycles, evt_ready=0 -> evt_valid=1 the next cycle, evt_ts=10, fifo_level=1; no second entry.
- Overflow: DEPTH=4, evt_ready=0, five spike edges at ts=3,6,9,12,15 -> level=4, overflow=1; pops return 3,6,9,12; clr_ovf pulse -> overflow=0.
- Full push+pop: FIFO full, edge coincides with evt_ready=1 -> level stays 4, overflow stays 0, new ts appended at the tail.
- Rate: WIN_CYCLES=16, spike_in toggling every cycle (one edge per 2 cycles) -> rate_valid pulses every 16 cycles, rate_out=8. Drop en for 5 cycles mid-window -> next pulse delayed by 5 cycles, and rate_out counts only enabled edges.
- Saturation and wrap: CNT_W=3, WIN_CYCLES=32, same toggle -> rate_out=7. TS_W=4 run for 20 cycles -> timestamps wrap 15 -> 0, and event captured at wrap shows 0.
